// File: rtl/status_clr_req_sck_if.sv
// Status-clear write/request bundle between the SPI register decode, the SCK-side
// request initiator and the HF_CLK-side clear receiver.
interface status_clr_req_sck_if;
    logic       clr_wr;
    logic [7:0] clr_lo;
    logic [5:0] clr_hi;
    logic       status_clr_ack_tgl_hf;
    logic       status_clr_req_tgl_sck;
    logic [7:0] status_clr_lo_sck;
    logic [5:0] status_clr_hi_sck;
    logic       clr_busy;
    logic       clr_merged;

    modport master (
        output clr_wr, clr_lo, clr_hi, status_clr_ack_tgl_hf,
        input  status_clr_req_tgl_sck, status_clr_lo_sck, status_clr_hi_sck,
               clr_busy, clr_merged
    );

    modport slave (
        input  clr_wr, clr_lo, clr_hi, status_clr_ack_tgl_hf,
        output status_clr_req_tgl_sck, status_clr_lo_sck, status_clr_hi_sck,
               clr_busy, clr_merged
    );
endinterface

// File: rtl/status_clr_req_sck.sv
// SCK-side status-clear requester: turns clear writes into a req toggle plus a stable
// 14-bit mask, and folds writes arriving mid-flight into one follow-up request.
module status_clr_req_sck (
    input  logic                 SCK,
    input  logic                 RST_sync,
    status_clr_req_sck_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t      state_q;
    logic [13:0] mask_q;
    logic [13:0] pend_q;
    logic        req_q;
    logic        ack_ff1_q;
    logic        ack_ff2_q;
    logic        ack_prev_q;
    logic        merged_q;

    logic [13:0] wr_mask;
    logic [13:0] reload_mask;
    logic        wr_nz;
    logic        ack_edge;

    assign wr_mask     = {bus.clr_hi, bus.clr_lo};
    assign wr_nz       = bus.clr_wr && (wr_mask != 14'd0);
    assign ack_edge    = ack_ff2_q ^ ack_prev_q;
    // A write landing on the ack cycle joins the reissued mask instead of waiting a round trip.
    assign reload_mask = pend_q | (wr_nz ? wr_mask : 14'd0);

    always_ff @(posedge SCK) begin
        if (RST_sync) begin
            state_q    <= IDLE;
            mask_q     <= 14'd0;
            pend_q     <= 14'd0;
            req_q      <= 1'b0;
            ack_ff1_q  <= 1'b0;
            ack_ff2_q  <= 1'b0;
            ack_prev_q <= 1'b0;
            merged_q   <= 1'b0;
        end else begin
            ack_ff1_q  <= bus.status_clr_ack_tgl_hf;
            ack_ff2_q  <= ack_ff1_q;
            ack_prev_q <= ack_ff2_q;

            case (state_q)
                IDLE: begin
                    if (wr_nz) begin
                        mask_q  <= wr_mask;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    req_q   <= ~req_q;
                    state_q <= WAIT_ACK;
                    if (wr_nz) begin
                        pend_q   <= reload_mask;
                        merged_q <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_edge) begin
                        if (reload_mask != 14'd0) begin
                            mask_q  <= reload_mask;
                            pend_q  <= 14'd0;
                            state_q <= LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                        if (wr_nz) merged_q <= 1'b1;
                    end else if (wr_nz) begin
                        pend_q   <= reload_mask;
                        merged_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.status_clr_req_tgl_sck = req_q;
    assign bus.status_clr_lo_sck      = mask_q[7:0];
    assign bus.status_clr_hi_sck      = mask_q[13:8];
    assign bus.clr_busy               = (state_q != IDLE) || (pend_q != 14'd0);
    assign bus.clr_merged             = merged_q;

endmodule

// File: doc/status_clr_req_sck.md
# status_clr_req_sck

SCK-domain initiator of the status-clear toggle handshake. It accepts status-clear writes decoded by the SPI register interface and converts them into a request toggle plus a stable 14-bit mask for the HF_CLK-side clear receiver. It synchronizes the returning ack toggle and merges any writes that arrive while a request is in flight into one follow-up request, so no clear bit is lost.

## Interface
- No parameters; mask width fixed at 14 (lo 8 + hi 6).
- SCK  in  1  SPI clock; only clock in the block; all logic on rising edge.
- RST_sync  in  1  synchronous, active-high reset (sampled on SCK rising edge).
- clr_wr  in  1  one-cycle strobe: status-clear register written.
- clr_lo  in  8  write data, mask bits [7:0]; valid with clr_wr.
- clr_hi  in  6  write data, mask bits [13:8]; valid with clr_wr.
- status_clr_ack_tgl_hf  in  1  ack toggle from HF_CLK domain; asynchronous, 2-flop synchronized here.
- status_clr_req_tgl_sck  out  1  request toggle to HF_CLK domain; registered.
- status_clr_lo_sck  out  8  mask [7:0]; registered; stable while request in flight.
- status_clr_hi_sck  out  6  mask [13:8]; registered; stable while request in flight.
- clr_busy  out  1  high when state != IDLE or pending mask non-empty.
- clr_merged  out  1  sticky: a write was merged into a pending request; cleared by reset only.

## Operation
- Reset (RST_sync=1 at an edge): state=IDLE, req toggle=0, mask outputs=0, pending mask=0, ack sync flops and ack_prev=0, clr_busy=0, clr_merged=0. Reset overrides all other inputs that cycle.
- Ack sync: ack_ff1 <= status_clr_ack_tgl_hf; ack_ff2 <= ack_ff1; ack_prev <= ack_ff2. ack_edge = ack_ff2 ^ ack_prev.
- Write mask w = {clr_hi, clr_lo}. A write with w==0 is ignored entirely (no state change, no flag).
- States:
  - IDLE: on clr_wr with w!=0: mask outputs <= w; go LOAD. ack_edge is discarded in IDLE.
  - LOAD: one cycle; req toggle <= ~req toggle; go WAIT_ACK. Mask outputs unchanged.
  - WAIT_ACK: hold toggle and mask. On ack_edge: if pending!=0, mask outputs <= pending, pending <= 0, go LOAD; else go IDLE.
- Merge: clr_wr with w!=0 in LOAD or WAIT_ACK: pending <= pending | w; clr_merged <= 1.
- Simultaneous clr_wr and ack_edge in WAIT_ACK: the new w is included in the next load (mask outputs <= pending | w, pending <= 0), go LOAD; clr_merged set.
- Mask outputs are never written in LOAD or WAIT_ACK except on the ack transition above; they keep their last value in IDLE.
- Toggle protocol: exactly one req toggle per LOAD; one ack_edge is expected per toggle. Both domains are reset together at system level; after reset req=ack=0.

## Timing
- clr_wr sampled at edge N (IDLE): mask outputs valid after N; toggle flips after N+1 (mask leads toggle by one SCK cycle so the receiver's mask sync settles no later than its toggle sync).
- clr_busy combinational from registered state/pending: high from edge N until the edge where WAIT_ACK returns to IDLE.
- Ack input change seen as ack_edge two SCK edges later (ack_ff2 updates at edge +2, ack_edge high in the following cycle); return to IDLE on the edge after that.
- Back-to-back: pending reissue costs ack-edge cycle + LOAD cycle before the next toggle.
- SCK may stop between transactions; the block simply freezes and resumes, no timeouts.

## Test plan
- Reset then clr_wr with w=14'h0005 -> mask=0x0005 after edge N, req toggle 0->1 after N+1, clr_busy=1; drive ack 0->1 -> IDLE 3 edges later, clr_busy=0, clr_merged=0.
- clr_wr with w=0 in IDLE -> no toggle, mask unchanged, clr_busy stays 0.
- In WAIT_ACK, writes 0x0100 then 0x2001 -> mask held at first value; on ack, mask=0x2101, second toggle 1->0, clr_merged=1; second ack -> IDLE.
- clr_wr (0x0002) on the same cycle as ack_edge -> next mask includes 0x0002, LOAD next, one extra toggle only.
- Spurious ack toggle while IDLE -> ignored, no state change; following request still completes only on its own ack edge.
- RST_sync asserted in WAIT_ACK with toggle=1 and pending!=0 -> all outputs 0 after that edge, pending discarded, clr_merged=0.
